// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment scan decoder (and, later, the encoder).
// Contents:
//   SEG_0 .. SEG_F, SEG_BLANK : 7-bit segment codes, active low, bit order g..a.
//   scan_state_e              : per-strobe capture state.
//   seg_decode_t / seg_decode : maps a 7-bit code to {legal, blank, nibble}.
package sseg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] nibble;
    } seg_decode_t;

    // Exact inverse of the hex encoder; anything that is neither a glyph nor
    // blank comes back with legal = 0 and blank = 0.
    function automatic seg_decode_t seg_decode(input logic [6:0] code);
        seg_decode_t r;
        r.legal  = 1'b1;
        r.blank  = 1'b0;
        r.nibble = 4'h0;
        case (code)
            SEG_0:     r.nibble = 4'h0;
            SEG_1:     r.nibble = 4'h1;
            SEG_2:     r.nibble = 4'h2;
            SEG_3:     r.nibble = 4'h3;
            SEG_4:     r.nibble = 4'h4;
            SEG_5:     r.nibble = 4'h5;
            SEG_6:     r.nibble = 4'h6;
            SEG_7:     r.nibble = 4'h7;
            SEG_8:     r.nibble = 4'h8;
            SEG_9:     r.nibble = 4'h9;
            SEG_A:     r.nibble = 4'hA;
            SEG_B:     r.nibble = 4'hB;
            SEG_C:     r.nibble = 4'hC;
            SEG_D:     r.nibble = 4'hD;
            SEG_E:     r.nibble = 4'hE;
            SEG_F:     r.nibble = 4'hF;
            SEG_BLANK: begin
                r.legal = 1'b0;
                r.blank = 1'b1;
            end
            default:   r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Double-flop synchronizer for a bundle of asynchronous inputs.
// Ports:
//   clk   : destination clock
//   reset : asynchronous active-high reset, both stages load RESET_VAL
//   d_i   : asynchronous input bundle (WIDTH bits)
//   q_o   : synchronized bundle, two clk edges behind d_i
module sync_2ff #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back capture stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sseg_scan_decoder.sv
// Snoops a multiplexed active-low seven-segment display bus and rebuilds the
// hex value, decimal point and legality of every digit.
// Ports:
//   clk        : system clock
//   reset      : asynchronous active-high reset
//   an         : anode enables, active low, asynchronous to clk
//   sseg       : segments, active low, bit7 = dp, bits6..0 = g..a, asynchronous
//   hex_out    : decoded nibble per digit, digit i at [4i+3:4i]
//   dp_out     : captured dp per digit, bus polarity
//   valid      : digit holds a legally decoded glyph
//   err        : last capture of the digit was a non-blank illegal pattern
//   frame_tick : one-cycle pulse once every digit has been captured
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_DIGITS-1:0]   an,
    input  logic [7:0]            sseg,
    output logic [4*N_DIGITS-1:0] hex_out,
    output logic [N_DIGITS-1:0]   dp_out,
    output logic [N_DIGITS-1:0]   valid,
    output logic [N_DIGITS-1:0]   err,
    output logic                  frame_tick
);

    localparam int              BW        = N_DIGITS + 8;
    localparam logic [7:0]      STABLE_C  = 8'(STABLE_CYCLES);
    localparam logic [N_DIGITS-1:0] ALL_DIG = {N_DIGITS{1'b1}};

    logic [BW-1:0]         bus_s;
    logic [BW-1:0]         prev_q;
    logic [N_DIGITS-1:0]   an_s;
    logic [7:0]            seg_s;
    logic [N_DIGITS-1:0]   sel_s;
    logic                  legal_s;
    logic                  changed_s;
    logic                  capture_s;
    logic [7:0]            cnt_inc_s;
    seg_decode_t           dec_s;

    scan_state_e           state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0] hex_q, hex_d;
    logic [N_DIGITS-1:0]   dp_q, dp_d;
    logic [N_DIGITS-1:0]   valid_q, valid_d;
    logic [N_DIGITS-1:0]   err_q, err_d;
    logic [N_DIGITS-1:0]   seen_q, seen_d;
    logic [N_DIGITS-1:0]   seen_base_s;
    logic                  tick_q, tick_d;

    // Idle bus is all ones (no anode, all segments dark).
    sync_2ff #(
        .WIDTH    (BW),
        .RESET_VAL({BW{1'b1}})
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d_i  ({an, sseg}),
        .q_o  (bus_s)
    );

    assign an_s      = bus_s[BW-1:8];
    assign seg_s     = bus_s[7:0];
    assign sel_s     = ~an_s;
    assign legal_s   = $onehot(sel_s);
    assign changed_s = (bus_s != prev_q);
    assign cnt_inc_s = cnt_q + 8'd1;
    assign dec_s     = seg_decode(seg_s[6:0]);

    // Strobe qualification FSM: a capture needs STABLE_CYCLES identical synced cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (legal_s) begin
                    state_d = SETTLE;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (!legal_s) begin
                    state_d = IDLE;
                end else if (changed_s) begin
                    cnt_d = 8'd1;
                end else if (cnt_inc_s == STABLE_C) begin
                    cnt_d     = cnt_inc_s;
                    capture_s = 1'b1;
                    state_d   = HELD;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            HELD: begin
                // Stay here until the bus moves, so one strobe gives one capture.
                if (changed_s) begin
                    if (legal_s) begin
                        state_d = SETTLE;
                        cnt_d   = 8'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = HELD;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Digit capture and frame bookkeeping.
    always_comb begin
        hex_d   = hex_q;
        dp_d    = dp_q;
        valid_d = valid_q;
        err_d   = err_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (capture_s && sel_s[i]) begin
                dp_d[i] = seg_s[7];
                if (dec_s.legal) begin
                    hex_d[4*i +: 4] = dec_s.nibble;
                    valid_d[i]      = 1'b1;
                    err_d[i]        = 1'b0;
                end else begin
                    valid_d[i] = 1'b0;
                    err_d[i]   = ~dec_s.blank;
                end
            end else begin
                dp_d[i] = dp_q[i];
            end
        end
        // The tick cycle is also the clear cycle; a capture landing in it keeps its bit.
        if (tick_q) begin
            seen_base_s = {N_DIGITS{1'b0}};
        end else begin
            seen_base_s = seen_q;
        end
        if (capture_s) begin
            seen_d = seen_base_s | sel_s;
            tick_d = (seen_base_s != ALL_DIG) && ((seen_base_s | sel_s) == ALL_DIG);
        end else begin
            seen_d = seen_base_s;
            tick_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            prev_q  <= {BW{1'b1}};
            hex_q   <= {(4*N_DIGITS){1'b0}};
            dp_q    <= {N_DIGITS{1'b1}};
            valid_q <= {N_DIGITS{1'b0}};
            err_q   <= {N_DIGITS{1'b0}};
            seen_q  <= {N_DIGITS{1'b0}};
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= bus_s;
            hex_q   <= hex_d;
            dp_q    <= dp_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            seen_q  <= seen_d;
            tick_q  <= tick_d;
        end
    end

    assign hex_out    = hex_q;
    assign dp_out     = dp_q;
    assign valid      = valid_q;
    assign err        = err_q;
    assign frame_tick = tick_q;

endmodule

// File: doc/sseg_scan_decoder.md
Name: sseg_scan_decoder

Overview:
- Receive-side counterpart of the hex-to-seven-segment encoder. Snoops a time-multiplexed, active-low segment and anode bus and reconstructs the hex value and decimal point of every digit.
- Sits beside the display driver as a self-check and readback path, so a bench or on-chip monitor can confirm that what is shown on the display matches the intended data.
- Filters strobe transitions and ghosting with a stability counter, flags illegal segment patterns, and emits a tick once per complete display frame.

Parameters:
- N_DIGITS, 4, number of multiplexed digits (anode lines), range 2..8.
- STABLE_CYCLES, 8, consecutive synchronized cycles a strobe must hold before capture, range 2..255.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- an  input  N_DIGITS  anode enables, active low, asynchronous to clk.
- sseg  input  8  segment bus, active low: bit7 = dp, bits6..0 = g..a. Asynchronous to clk.
- hex_out  output  4*N_DIGITS  decoded nibble per digit; digit i occupies [4i+3:4i].
- dp_out  output  N_DIGITS  captured dp per digit, raw bus polarity.
- valid  output  N_DIGITS  digit i holds a legally decoded glyph.
- err  output  N_DIGITS  last capture of digit i was an illegal, non-blank pattern.
- frame_tick  output  1  one-cycle pulse when every digit has been captured since the previous tick.

Behaviour:
- Reset values: hex_out = 0, dp_out = all ones, valid = 0, err = 0, frame_tick = 0. The synchronizer stages load all ones (bus inactive). Reset is honoured at any time, including mid-settle.
- Input path: two-flop synchronizer on an and sseg. All further logic uses the synced values, called "bus" below.
- Strobe legal: exactly one bit of bus.an is 0. Zero or multiple low bits are illegal.
- States:
  - IDLE: no legal strobe.
  - SETTLE: counting stability.
  - HELD: digit captured; wait for the bus to change.
- Transitions:
  - IDLE to SETTLE: on a legal strobe; cnt is set to 1.
  - SETTLE to IDLE: if the strobe becomes illegal.
  - SETTLE restart: if {an, sseg} differs from the previous cycle, stay in SETTLE and set cnt to 1.
  - SETTLE count: if {an, sseg} is unchanged, increment cnt.
  - SETTLE to HELD: when cnt reaches STABLE_CYCLES, capture at that edge. The bus must be identical for STABLE_CYCLES consecutive synced cycles.
  - HELD to SETTLE: on any change with a legal strobe; cnt is set to 1.
  - HELD to IDLE: on any change with an illegal strobe.
  - A digit is captured at most once per strobe period.
- Latency: the glitch-free window to capture is 2 + STABLE_CYCLES clk edges. Outputs are registered.
- Decode, sseg[6:0] to nibble, exact inverse of the encoder:
  - 40 = 0, 79 = 1, 24 = 2, 30 = 3, 19 = 4, 12 = 5, 02 = 6, 78 = 7
  - 00 = 8, 10 = 9, 08 = A, 03 = b, 46 = C, 21 = d, 06 = E, 0E = F
- Capture of digit i, where i is the index of the low anode:
  - legal glyph: hex_out[i] = nibble, valid[i] = 1, err[i] = 0.
  - 7F (blank): hex_out[i] unchanged, valid[i] = 0, err[i] = 0.
  - any other pattern: hex_out[i] unchanged, valid[i] = 0, err[i] = 1.
  - In every case dp_out[i] = sseg[7], and seen[i] is set.
- Frame:
  - seen is an internal N_DIGITS mask.
  - When the capture makes seen all ones, frame_tick pulses on the next cycle and seen clears to only the bit just captured, if the capture coincided. Otherwise seen clears to 0.
  - Re-capturing an already-seen digit does not tick.
- Simultaneous events: capture and the frame-clear happen in the same cycle. The capture wins for its own bit.
- Other digits' outputs hold indefinitely. There is no timeout.

Decomposition:
- Shared package sseg_pkg:
  - 7-bit segment-code constants for 0..F and SEG_BLANK.
  - Decode function returning {legal, blank, nibble}.
  - State enum typedef {IDLE, SETTLE, HELD}.
  - The encoder may later reuse the constants.
- One sub-module, sync_2ff: a parameterized-width double-flop synchronizer with asynchronous reset to a parameterized value. Instantiate it once for {an, sseg}.

Test Plan:
1. Reset, then scan digits 0..3 (an = E,D,B,7) with codes 79,24,30,19 and dp = 1, each held 20 cycles. Required: hex_out = 16'h4321, valid = F, err = 0, dp_out = F, exactly one frame_tick after digit 3 captures.
2. Hold an = E for exactly STABLE_CYCLES-1 synced cycles, then change. Required: no capture; valid[0] stays 0.
3. Digit 2 carries pattern 55, then 7F. Required: 55 gives err[2] = 1, valid[2] = 0, hex unchanged. 7F gives err[2] = 0, valid[2] = 0.
4. Drive an = C (two digits low) for 50 cycles. Required: no capture and no frame_tick. An an = F gap between strobes causes no capture.
5. Toggle sseg every 3 cycles while an = 7. Required: no capture. Then hold 0E. Required: hex digit 3 = F after the 2 + STABLE_CYCLES window.
6. Assert reset mid-SETTLE and again after a full frame. Required: all outputs return to reset values immediately, and the next full scan produces a fresh frame_tick.
